cpu_ram_addr_gen: RTL and testbench
===================================

# cpu_ram_addr_gen

Burst address generator for the CPU-side RAM access path of the LU example. It accepts one burst request at a time, with a base address, word count and stride, over a valid/ready handshake. It then emits one global word address per beat on a valid/ready output stream. The stream feeds the per-lane address swizzle stages directly, so every lane sees the same global address sequence.

## Interface

Parameters:

- TOTAL_BITS, 16, width of global word address, stride and output address
- LEN_BITS, 8, width of burst length field

Ports:

- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- i_req_valid  input  1  burst request valid
- o_req_ready  output  1  generator can accept a request
- i_req_base  input  TOTAL_BITS  first global address of the burst
- i_req_stride  input  TOTAL_BITS  address increment per beat, unsigned, modular
- i_req_len  input  LEN_BITS  number of beats; 0 means an empty burst
- i_req_write  input  1  burst direction tag, copied to every beat
- o_addr_valid  output  1  address beat valid
- i_addr_ready  input  1  downstream accepts the beat
- o_addr  output  TOTAL_BITS  current global address
- o_write  output  1  direction tag of the current burst
- o_last  output  1  current beat is the final beat of the burst
- o_done  output  1  one-cycle pulse when the burst completes
- o_busy  output  1  burst in progress (state != IDLE)

## Operation

- The state machine has two states, IDLE and RUN.
- Reset forces state IDLE and sets every output to 0, except o_req_ready, which is 1.
- o_req_ready = (state == IDLE). A request is accepted on a clock edge where i_req_valid && o_req_ready. Requests are never queued.
- On acceptance with i_req_len != 0:
  - register base into o_addr, register stride and the write tag;
  - set remaining = i_req_len;
  - set o_addr_valid = 1, o_last = (i_req_len == 1), and enter RUN.
- On acceptance with i_req_len == 0:
  - stay in IDLE;
  - o_addr_valid stays 0;
  - o_done pulses on the next cycle.
- RUN, beat accepted (o_addr_valid && i_addr_ready):
  - if remaining == 1: o_addr_valid <= 0, o_last <= 0, o_done <= 1 for one cycle, state <= IDLE.
  - otherwise: o_addr <= o_addr + stride, truncated to TOTAL_BITS (silent wrap past all-ones); remaining <= remaining - 1; o_last <= (remaining == 2).
- RUN, no accept: o_addr, o_write, o_last and o_addr_valid hold. A valid beat is never withdrawn or changed before it is accepted.
- The remaining counter is LEN_BITS wide, so the maximum burst is 2^LEN_BITS - 1 beats.
- While in RUN, i_req_valid is ignored and no fields are sampled.
- o_write is meaningful only while o_addr_valid is 1. It holds its last value otherwise.
- Reset asserted mid-burst takes effect at the next edge:
  - the beat is dropped;
  - o_done does not pulse;
  - the block returns to the reset values;
  - the aborted burst is never resumed.

## Timing

- Request accepted at edge N: o_addr_valid = 1 and o_addr = base during cycle N+1.
- Throughput is one beat per cycle while i_addr_ready stays high. A burst of L beats with no stalls occupies cycles N+1 to N+L.
- Last beat accepted at edge M:
  - during cycle M+1, o_done = 1, o_busy = 0 and o_req_ready = 1;
  - the earliest next request is accepted at edge M+1, and its first beat is valid at M+2.
- Empty-burst request accepted at edge N: o_done = 1 during cycle N+1 only. The block stays ready throughout.
- All outputs are registered. No combinational path exists from i_addr_ready or i_req_valid to any output.
- The downstream swizzle stage adds its own 1-cycle register. The beat accepted at edge E appears as a lane address at edge E+1; this block does not account for it.

## Test plan

- Basic burst, no stalls: base 0x0010, stride 1, len 4, ready held high.
  - Required: addresses 0x0010, 0x0011, 0x0012, 0x0013 on consecutive cycles.
  - o_last only on 0x0013; o_done pulses the cycle after; o_req_ready returns to 1 at the same time.
- Stride with wrap (TOTAL_BITS=16): base 0xFFFE, stride 3, len 3.
  - Required: addresses 0xFFFE, 0x0001, 0x0004, with o_last on 0x0004.
- Backpressure: len 4, stride 1, i_addr_ready low for the first 3 valid cycles, then high.
  - Required: 0x0010 held stable with valid high for 3 cycles, then 4 beats accepted in order.
  - No beat duplicated or skipped.
- Empty burst: len 0.
  - Required: o_addr_valid never asserts; o_done is high for exactly 1 cycle after acceptance; o_req_ready stays 1.
- Request while busy: a second request (base 0x0100) held valid throughout an 8-beat burst.
  - Required: o_req_ready stays low, so the request is not taken.
  - The first burst's addresses are unaffected, and the second request is accepted in the cycle after the first burst's o_done.
- Reset mid-burst: reset pulsed after beat 2 of a 6-beat burst.
  - Required: the next cycle shows o_addr_valid = 0, o_done = 0, o_busy = 0, o_req_ready = 1.
  - A new request then starts cleanly from its own base.

Source files
------------

// File: rtl/cpu_ram_addr_gen_if.sv
// Request and address-beat bundle for the CPU-side RAM burst address generator.
// The master issues bursts and accepts beats; the generator is the slave.
interface cpu_ram_addr_gen_if #(
  parameter int TOTAL_BITS = 16,
  parameter int LEN_BITS   = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic [TOTAL_BITS-1:0] req_base;
  logic [TOTAL_BITS-1:0] req_stride;
  logic [LEN_BITS-1:0]   req_len;
  logic                  req_write;
  logic                  addr_valid;
  logic                  addr_ready;
  logic [TOTAL_BITS-1:0] addr;
  logic                  write;
  logic                  last;
  logic                  done;
  logic                  busy;

  modport master (
    output req_valid, req_base, req_stride, req_len, req_write, addr_ready,
    input  req_ready, addr_valid, addr, write, last, done, busy
  );

  modport slave (
    input  req_valid, req_base, req_stride, req_len, req_write, addr_ready,
    output req_ready, addr_valid, addr, write, last, done, busy
  );
endinterface

// File: rtl/cpu_ram_addr_gen.sv
// Burst address generator: takes one base/stride/length request at a time and
// emits one global word address per beat on a valid/ready stream.
module cpu_ram_addr_gen #(
  parameter int TOTAL_BITS = 16,
  parameter int LEN_BITS   = 8
) (
  input logic               clk,
  input logic               reset,
  cpu_ram_addr_gen_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state;
  state_t                state_next;
  logic [TOTAL_BITS-1:0] addr;
  logic [TOTAL_BITS-1:0] stride;
  logic [LEN_BITS-1:0]   remaining;
  logic                  addr_valid;
  logic                  write;
  logic                  last;
  logic                  done;
  logic                  req_ready;
  logic                  busy;
  logic                  req_take;
  logic                  beat_take;
  logic                  final_beat;

  // Address advance wraps silently past all-ones.
  function automatic logic [TOTAL_BITS-1:0] wrap_add(
    input logic [TOTAL_BITS-1:0] a,
    input logic [TOTAL_BITS-1:0] b
  );
    return a + b;
  endfunction

  assign req_take   = bus.req_valid && req_ready;
  assign beat_take  = addr_valid && bus.addr_ready;
  assign final_beat = (remaining == LEN_BITS'(1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (req_take && (bus.req_len != '0)) state_next = RUN;
      RUN:     if (beat_take && final_beat)          state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Ready and busy come straight from the state register, so they are registered.
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE:    req_ready = 1'b1;
      RUN:     busy      = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr       <= '0;
      stride     <= '0;
      remaining  <= '0;
      addr_valid <= 1'b0;
      write      <= 1'b0;
      last       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (req_take) begin
        if (bus.req_len != '0) begin
          addr       <= bus.req_base;
          stride     <= bus.req_stride;
          write      <= bus.req_write;
          remaining  <= bus.req_len;
          addr_valid <= 1'b1;
          last       <= (bus.req_len == LEN_BITS'(1));
        end else begin
          done <= 1'b1;
        end
      end else if (beat_take) begin
        if (final_beat) begin
          addr_valid <= 1'b0;
          last       <= 1'b0;
          done       <= 1'b1;
        end else begin
          addr      <= wrap_add(addr, stride);
          remaining <= remaining - LEN_BITS'(1);
          last      <= (remaining == LEN_BITS'(2));
        end
      end
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.busy       = busy;
  assign bus.addr_valid = addr_valid;
  assign bus.addr       = addr;
  assign bus.write      = write;
  assign bus.last       = last;
  assign bus.done       = done;

endmodule

// File: tb/tb_cpu_ram_addr_gen.sv
// Bench for cpu_ram_addr_gen: directed bursts plus random traffic, with beats
// and completions matched against a queue-based reference model.
module tb_cpu_ram_addr_gen;

  localparam int TB = 16;
  localparam int LB = 8;

  typedef struct {
    logic [TB-1:0] addr;
    logic          write;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   beats_acc = 0;
  int   rdy_mode = 0;
  beat_t beat_q[$];
  int    done_q[$];

  cpu_ram_addr_gen_if #(.TOTAL_BITS(TB), .LEN_BITS(LB)) bus ();

  cpu_ram_addr_gen #(.TOTAL_BITS(TB), .LEN_BITS(LB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Downstream ready: 0 = always ready, 1 = random, 2 = held low
  initial begin
    bus.addr_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.addr_ready = 1'b1;
        1:       bus.addr_ready = ($urandom_range(0, 3) != 0);
        default: bus.addr_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the reference model whenever a beat or a completion is seen
  initial begin
    logic          prev_hold;
    logic [TB-1:0] prev_addr;
    logic          prev_last;
    logic          prev_write;
    beat_t         b;
    prev_hold  = 1'b0;
    prev_addr  = '0;
    prev_last  = 1'b0;
    prev_write = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check("hold_valid", 32'(bus.addr_valid), 32'd1);
          check("hold_addr",  32'(bus.addr),  32'(prev_addr));
          check("hold_last",  32'(bus.last),  32'(prev_last));
          check("hold_write", 32'(bus.write), 32'(prev_write));
        end
        check("busy_not_ready", 32'(bus.busy), 32'(!bus.req_ready));
        if (bus.addr_valid && bus.addr_ready) begin
          if (beat_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual addr=0x%0h required no beat", bus.addr);
          end else begin
            b = beat_q.pop_front();
            check("beat_addr",  32'(bus.addr),  32'(b.addr));
            check("beat_write", 32'(bus.write), 32'(b.write));
            check("beat_last",  32'(bus.last),  32'(b.last));
            beats_acc++;
          end
        end
        if (bus.done) begin
          if (done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 required=0");
          end else begin
            void'(done_q.pop_front());
            check("done_after_all_beats", 32'(beat_q.size()), 32'd0);
          end
        end
        prev_hold  = bus.addr_valid && !bus.addr_ready;
        prev_addr  = bus.addr;
        prev_last  = bus.last;
        prev_write = bus.write;
      end
    end
  end

  // Issue one request, waiting (bounded) for ready; returns at accept edge + 1.
  task automatic send_req(input logic [TB-1:0] base, input logic [TB-1:0] stride,
                          input logic [LB-1:0] len, input logic wr,
                          output int waited, output logic done_at_take);
    int n = 0;
    bus.req_base   = base;
    bus.req_stride = stride;
    bus.req_len    = len;
    bus.req_write  = wr;
    bus.req_valid  = 1'b1;
    while (!bus.req_ready && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    waited       = n;
    done_at_take = bus.done;
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_timeout actual ready=0 required ready=1 base=0x%0h", base);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int i = 0; i < int'(len); i++) begin
      beat_t b;
      b.addr  = TB'((int'(base) + i * int'(stride)) % 65536);
      b.write = wr;
      b.last  = (i == int'(len) - 1);
      beat_q.push_back(b);
    end
    done_q.push_back(int'(len));
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || done_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.busy || done_q.size() != 0) begin
      errors++;
      $display("FAIL idle_timeout actual busy=%0d pending=%0d required idle", bus.busy, done_q.size());
    end
  endtask

  initial begin
    int   w;
    logic dt;
    int   target;
    int   n;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_base   = '0;
    bus.req_stride = '0;
    bus.req_len    = '0;
    bus.req_write  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready",  32'(bus.req_ready),  32'd1);
    check("rst_addr_valid", 32'(bus.addr_valid), 32'd0);
    check("rst_done",       32'(bus.done),       32'd0);
    check("rst_busy",       32'(bus.busy),       32'd0);
    check("rst_last",       32'(bus.last),       32'd0);
    check("rst_addr",       32'(bus.addr),       32'd0);
    check("rst_write",      32'(bus.write),      32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);

    // Basic burst, no stalls
    rdy_mode = 0;
    send_req(16'h0010, 16'd1, 8'd4, 1'b1, w, dt);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("basic_valid", 32'(bus.addr_valid), 32'd1);
      check("basic_addr",  32'(bus.addr), 32'h10 + 32'(i));
      check("basic_last",  32'(bus.last), 32'(i == 3));
    end
    @(negedge clk);
    check("basic_done",  32'(bus.done),      32'd1);
    check("basic_ready", 32'(bus.req_ready), 32'd1);
    check("basic_busy",  32'(bus.busy),      32'd0);
    @(negedge clk);
    check("basic_done_pulse", 32'(bus.done), 32'd0);

    // Stride with wrap
    send_req(16'hFFFE, 16'd3, 8'd3, 1'b0, w, dt);
    @(negedge clk);
    check("wrap_addr0", 32'(bus.addr), 32'hFFFE);
    @(negedge clk);
    check("wrap_addr1", 32'(bus.addr), 32'h0001);
    @(negedge clk);
    check("wrap_addr2", 32'(bus.addr), 32'h0004);
    check("wrap_last",  32'(bus.last), 32'd1);
    wait_idle();

    // Backpressure for the first three valid cycles
    rdy_mode = 2;
    @(negedge clk);
    send_req(16'h0010, 16'd1, 8'd4, 1'b1, w, dt);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.addr_valid), 32'd1);
      check("bp_addr",  32'(bus.addr), 32'h10);
      check("bp_ready_low", 32'(bus.addr_ready), 32'd0);
    end
    rdy_mode = 0;
    wait_idle();

    // Empty burst
    @(negedge clk);
    send_req(16'h0055, 16'd1, 8'd0, 1'b1, w, dt);
    @(negedge clk);
    check("empty_valid", 32'(bus.addr_valid), 32'd0);
    check("empty_done",  32'(bus.done),       32'd1);
    check("empty_ready", 32'(bus.req_ready),  32'd1);
    @(negedge clk);
    check("empty_valid2", 32'(bus.addr_valid), 32'd0);
    check("empty_done2",  32'(bus.done),       32'd0);
    check("empty_ready2", 32'(bus.req_ready),  32'd1);

    // Second request held valid through an 8-beat burst
    send_req(16'h0040, 16'd2, 8'd8, 1'b0, w, dt);
    send_req(16'h0100, 16'd1, 8'd2, 1'b1, w, dt);
    check("busy_req_wait",     32'(w),  32'd8);
    check("busy_req_after_done", 32'(dt), 32'd1);
    wait_idle();

    // Reset after beat 2 of a 6-beat burst
    @(negedge clk);
    target = beats_acc + 2;
    send_req(16'h0200, 16'd2, 8'd6, 1'b1, w, dt);
    n = 0;
    while (beats_acc < target && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    reset = 1'b1;
    beat_q.delete();
    done_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rstmid_valid", 32'(bus.addr_valid), 32'd0);
    check("rstmid_done",  32'(bus.done),       32'd0);
    check("rstmid_busy",  32'(bus.busy),       32'd0);
    check("rstmid_ready", 32'(bus.req_ready),  32'd1);
    send_req(16'h0300, 16'd1, 8'd3, 1'b0, w, dt);
    @(negedge clk);
    check("rstmid_new_addr", 32'(bus.addr), 32'h0300);
    wait_idle();

    // Random traffic with random backpressure
    rdy_mode = 1;
    for (int k = 0; k < 25; k++) begin
      logic [LB-1:0] len;
      len = ($urandom_range(0, 3) == 0) ? 8'd0 : LB'($urandom_range(1, 12));
      send_req(TB'($urandom), TB'($urandom), len, 1'($urandom), w, dt);
    end
    send_req(TB'($urandom), TB'($urandom), 8'd255, 1'b1, w, dt);
    wait_idle();
    repeat (2) @(negedge clk);

    check("final_beats_pending", 32'(beat_q.size()), 32'd0);
    check("final_done_pending",  32'(done_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
